// File: rtl/lsu_ctrl_if.sv
// Request, memory-stage command and writeback response bundle for lsu_ctrl.
// slave is the lsu_ctrl side; master is the execute/memory/writeback environment.
interface lsu_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_is_load;
  logic             in_is_store;
  logic [2:0]       in_funct3;
  logic [31:0]      in_addr;
  logic [31:0]      in_wdata;
  logic [TAG_W-1:0] in_tag;

  logic             mem_access;
  logic             read;
  logic             wen;
  logic [2:0]       readop;
  logic [7:0]       wmask;
  logic [31:0]      raddr;
  logic [31:0]      waddr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_rdata;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport slave (
    input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_tag,
    input  rdata, out_ready,
    output in_ready, mem_access, read, wen, readop, wmask, raddr, waddr, wdata,
    output out_valid, out_rdata, out_tag, out_err
  );

  modport master (
    output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata, in_tag,
    output rdata, out_ready,
    input  in_ready, mem_access, read, wen, readop, wmask, raddr, waddr, wdata,
    input  out_valid, out_rdata, out_tag, out_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding RV32 load/store controller: accepts one request, issues a
// one-cycle memory strobe, captures load data and holds the response until taken.
module lsu_ctrl #(
  parameter int TAG_W = 5
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t           state, state_d;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      out_rdata_q;
  logic [TAG_W-1:0] tag_q;
  logic             is_load_q;
  logic             out_err_q;

  logic             req_load, req_store, req_mem;
  logic             misalign, bad_f3, req_err, accept;
  logic [3:0]       lane_mask;

  // Request decode; load wins when both kind flags are set.
  always_comb begin
    req_load  = bus.in_is_load;
    req_store = bus.in_is_store && !bus.in_is_load;
    req_mem   = req_load || req_store;
    case (bus.in_funct3)
      3'd1, 3'd5: misalign = bus.in_addr[0];
      3'd2:       misalign = |bus.in_addr[1:0];
      default:    misalign = 1'b0;
    endcase
    bad_f3  = req_load ? (bus.in_funct3 == 3'd3 || bus.in_funct3[2:1] == 2'b11)
                       : (bus.in_funct3 >= 3'd3);
    req_err = req_mem && (misalign || bad_f3);
    accept  = (state == IDLE) && bus.in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.in_valid) state_d = (req_err || !req_mem) ? DONE : ACCESS;
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error and no-access requests finish with zero data straight from the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      is_load_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_rdata_q <= '0;
    end else begin
      if (accept) begin
        f3_q        <= bus.in_funct3;
        addr_q      <= bus.in_addr;
        wdata_q     <= bus.in_wdata;
        tag_q       <= bus.in_tag;
        is_load_q   <= req_load;
        out_err_q   <= req_err;
        out_rdata_q <= '0;
      end
      if (state == CAPTURE) out_rdata_q <= is_load_q ? bus.rdata : '0;
    end
  end

  always_comb begin
    case (f3_q[1:0])
      2'd0:    lane_mask = 4'b0001 << addr_q[1:0];
      2'd1:    lane_mask = 4'b0011 << addr_q[1:0];
      2'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.mem_access = 1'b0;
    bus.read       = 1'b0;
    bus.wen        = 1'b0;
    bus.raddr      = '0;
    bus.readop     = '0;
    bus.waddr      = '0;
    bus.wmask      = '0;
    bus.wdata      = '0;
    bus.out_valid  = (state == DONE);
    bus.out_rdata  = out_rdata_q;
    bus.out_tag    = tag_q;
    bus.out_err    = out_err_q;
    case (state)
      ACCESS: begin
        bus.mem_access = 1'b1;
        bus.read       = is_load_q;
        bus.wen        = !is_load_q;
        bus.raddr      = addr_q;
        bus.readop     = f3_q;
        bus.waddr      = {addr_q[31:2], 2'b00};
        bus.wmask      = {4'b0000, lane_mask};
        bus.wdata      = wdata_q << {addr_q[1:0], 3'b000};
      end
      CAPTURE: begin
        bus.raddr  = addr_q;
        bus.readop = f3_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: the bench plays execute, memory and writeback stages.
module tb_lsu_ctrl;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [31:0]      rdata;
    logic [TAG_W-1:0] tag;
    logic             err;
  } resp_t;

  typedef struct packed {
    int               lat;
    logic [31:0]      acc_cyc;
    logic             saw_acc;
    logic             c_read;
    logic             c_wen;
    logic [31:0]      c_raddr;
    logic [2:0]       c_readop;
    logic [31:0]      c_waddr;
    logic [7:0]       c_wmask;
    logic [31:0]      c_wdata;
    resp_t            r;
  } obs_t;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = '0;
  resp_t       sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  lsu_ctrl_if #(.TAG_W(TAG_W)) bus ();
  lsu_ctrl #(.TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'h2000_0000) return 32'h8001_1234;
    return {a[15:2], 2'b00, ~a[15:2], 2'b11};
  endfunction

  // Memory stage model: extended load data for the address/op the DUT presents.
  function automatic logic [31:0] mem_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] sh;
    sh = mem_word(a) >> (8 * a[1:0]);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'h0, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'h0, sh[15:0]};
      default: return mem_word(a);
    endcase
  endfunction

  function automatic logic model_err(input req_t q);
    if (q.ld) begin
      if (q.f3 == 3'd2) return q.a[1:0] != 2'b00;
      if (q.f3 == 3'd1 || q.f3 == 3'd5) return q.a[0];
      return q.f3 == 3'd3 || q.f3 == 3'd6 || q.f3 == 3'd7;
    end
    if (q.st) begin
      if (q.f3 == 3'd2) return q.a[1:0] != 2'b00;
      if (q.f3 == 3'd1) return q.a[0];
      return q.f3 != 3'd0;
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_mask(input req_t q);
    if (q.f3 == 3'd0) return 8'h01 << q.a[1:0];
    if (q.f3 == 3'd1) return 8'h03 << q.a[1:0];
    return 8'h0F;
  endfunction

  assign bus.rdata = mem_load(bus.raddr, bus.readop);

  req_t tbl [12] = '{
    '{1'b0, 1'b0, 3'd2, 32'h8000_0001, 32'h0},
    '{1'b1, 1'b0, 3'd0, 32'h8000_0001, 32'h0},
    '{1'b1, 1'b0, 3'd4, 32'h8000_0003, 32'h0},
    '{1'b1, 1'b0, 3'd0, 32'h8000_0003, 32'h0},
    '{1'b1, 1'b0, 3'd5, 32'h8000_0002, 32'h0},
    '{1'b0, 1'b1, 3'd1, 32'h8000_0102, 32'hCAFE_BEEF},
    '{1'b0, 1'b1, 3'd1, 32'h8000_0101, 32'hCAFE_BEEF},
    '{1'b0, 1'b1, 3'd3, 32'h8000_0100, 32'h1234_5678},
    '{1'b1, 1'b0, 3'd6, 32'h8000_0100, 32'h0},
    '{1'b1, 1'b0, 3'd2, 32'h8000_0100, 32'h0},
    '{1'b0, 1'b1, 3'd0, 32'h8000_0001, 32'h0000_0055},
    '{1'b1, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF}
  };

  // Present a request, wait for its accept edge, then follow it until out_valid.
  task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [TAG_W-1:0] tg, output obs_t o);
    o = '0;
    o.lat = -1;
    bus.in_valid = 1'b1; bus.in_is_load = ld; bus.in_is_store = st;
    bus.in_funct3 = f3; bus.in_addr = a; bus.in_wdata = wd; bus.in_tag = tg;
    for (int i = 0; i < 20 && !bus.in_ready; i++) begin @(posedge clk); #1; end
    if (!bus.in_ready) begin bus.in_valid = 1'b0; return; end
    @(posedge clk); #1;
    o.acc_cyc = cyc;
    bus.in_valid = 1'b0; bus.in_is_load = 1'($urandom); bus.in_is_store = 1'($urandom);
    bus.in_funct3 = 3'($urandom); bus.in_addr = $urandom; bus.in_wdata = $urandom;
    bus.in_tag = TAG_W'($urandom);
    for (int k = 0; k < 20; k++) begin
      if (bus.mem_access) begin
        o.saw_acc = 1'b1; o.c_read = bus.read; o.c_wen = bus.wen;
        o.c_raddr = bus.raddr; o.c_readop = bus.readop; o.c_waddr = bus.waddr;
        o.c_wmask = bus.wmask; o.c_wdata = bus.wdata;
      end
      if (bus.out_valid) begin
        o.lat = k + 1;
        o.r = '{bus.out_rdata, bus.out_tag, bus.out_err};
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_handshake got in_ready=%b out_valid=%b exp 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if ({bus.mem_access, bus.read, bus.wen} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b exp 000", {bus.mem_access, bus.read, bus.wen});
    end
    checks++;
    if ({bus.raddr, bus.waddr, bus.wdata, bus.wmask, bus.readop} !== '0) begin
      errors++; $display("FAIL reset_cmd got raddr=%h waddr=%h wdata=%h wmask=%h readop=%h exp 0",
                         bus.raddr, bus.waddr, bus.wdata, bus.wmask, bus.readop);
    end
    checks++;
    if ({bus.out_rdata, bus.out_tag, bus.out_err} !== '0) begin
      errors++; $display("FAIL reset_resp got rdata=%h tag=%h err=%b exp 0", bus.out_rdata, bus.out_tag, bus.out_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.mem_access !== 1'b0) begin
      errors++; $display("FAIL reset_idle_hold got in_ready=%b mem_access=%b exp 1 0", bus.in_ready, bus.mem_access);
    end
  endtask

  task automatic test_sb();
    obs_t  o;
    resp_t e;
    sb_q.push_back('{32'h0, 5'd3, 1'b0});
    do_req(1'b0, 1'b1, 3'd0, 32'h8000_0003, 32'h0000_00AB, 5'd3, o);
    checks++;
    if (o.lat !== 3) begin errors++; $display("FAIL sb_latency got %0d exp 3", o.lat); end
    checks++;
    if ({o.saw_acc, o.c_wen, o.c_read} !== 3'b110) begin
      errors++; $display("FAIL sb_strobes got acc/wen/read=%b exp 110", {o.saw_acc, o.c_wen, o.c_read});
    end
    checks++;
    if (o.c_waddr !== 32'h8000_0000 || o.c_wmask !== 8'h08 || o.c_wdata !== 32'hAB00_0000) begin
      errors++; $display("FAIL sb_cmd got waddr=%h wmask=%h wdata=%h exp 80000000 08 ab000000",
                         o.c_waddr, o.c_wmask, o.c_wdata);
    end
    e = sb_q.pop_front();
    checks++;
    if (o.r !== e) begin errors++; $display("FAIL sb_resp got %h exp %h", o.r, e); end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL sb_release got out_valid=%b in_ready=%b exp 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_lh();
    obs_t  o;
    resp_t e;
    sb_q.push_back('{32'hFFFF_8001, 5'd7, 1'b0});
    do_req(1'b1, 1'b0, 3'd1, 32'h8000_0002, 32'h0, 5'd7, o);
    checks++;
    if (o.lat !== 3 || {o.saw_acc, o.c_read, o.c_wen} !== 3'b110) begin
      errors++; $display("FAIL lh_access got lat=%0d acc/read/wen=%b exp 3 110", o.lat, {o.saw_acc, o.c_read, o.c_wen});
    end
    checks++;
    if (o.c_raddr !== 32'h8000_0002 || o.c_readop !== 3'd1) begin
      errors++; $display("FAIL lh_cmd got raddr=%h readop=%0d exp 80000002 1", o.c_raddr, o.c_readop);
    end
    e = sb_q.pop_front();
    checks++;
    if (o.r !== e) begin errors++; $display("FAIL lh_resp got %h exp %h", o.r, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    obs_t  o;
    resp_t e;
    sb_q.push_back('{32'h0, 5'd9, 1'b1});
    do_req(1'b1, 1'b0, 3'd2, 32'h8000_0001, 32'h0, 5'd9, o);
    checks++;
    if (o.lat !== 1 || o.saw_acc !== 1'b0) begin
      errors++; $display("FAIL misaligned_path got lat=%0d mem_access_seen=%b exp 1 0", o.lat, o.saw_acc);
    end
    e = sb_q.pop_front();
    checks++;
    if (o.r !== e) begin errors++; $display("FAIL misaligned_resp got %h exp %h", o.r, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_mixed();
    obs_t  o;
    resp_t e;
    logic  short_path, eff_ld;
    for (int unsigned i = 0; i < 12; i++) begin
      short_path = model_err(tbl[i]) || !(tbl[i].ld || tbl[i].st);
      eff_ld     = tbl[i].ld;
      sb_q.push_back('{(short_path || !eff_ld) ? 32'h0 : mem_load(tbl[i].a, tbl[i].f3),
                       TAG_W'(i + 16), model_err(tbl[i])});
      do_req(tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, TAG_W'(i + 16), o);
      checks++;
      if (o.lat !== (short_path ? 1 : 3) || o.saw_acc !== !short_path) begin
        errors++; $display("FAIL mixed_path[%0d] got lat=%0d acc=%b exp %0d %b",
                           i, o.lat, o.saw_acc, short_path ? 1 : 3, !short_path);
      end
      if (!short_path) begin
        checks++;
        if (o.c_read !== eff_ld || o.c_wen !== !eff_ld || o.c_raddr !== tbl[i].a ||
            o.c_readop !== tbl[i].f3 || o.c_waddr !== {tbl[i].a[31:2], 2'b00}) begin
          errors++; $display("FAIL mixed_cmd[%0d] got read=%b wen=%b raddr=%h readop=%0d waddr=%h",
                             i, o.c_read, o.c_wen, o.c_raddr, o.c_readop, o.c_waddr);
        end
        if (!eff_ld) begin
          checks++;
          if (o.c_wmask !== model_mask(tbl[i]) || o.c_wdata !== (tbl[i].wd << (8 * tbl[i].a[1:0]))) begin
            errors++; $display("FAIL mixed_store[%0d] got wmask=%h wdata=%h exp %h %h", i, o.c_wmask,
                               o.c_wdata, model_mask(tbl[i]), tbl[i].wd << (8 * tbl[i].a[1:0]));
          end
        end
      end
      e = sb_q.pop_front();
      checks++;
      if (o.r !== e) begin errors++; $display("FAIL mixed_resp[%0d] got %h exp %h", i, o.r, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    obs_t  o;
    resp_t e;
    logic  bad = 1'b0;
    bus.out_ready = 1'b0;
    sb_q.push_back('{32'h8001_1234, 5'h15, 1'b0});
    do_req(1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'h0, 5'h15, o);
    // A competing request sits on the inputs while the response is stalled.
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_is_store = 1'b0;
    bus.in_funct3 = 3'd2; bus.in_addr = 32'h8000_0040; bus.in_tag = 5'h02;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || {bus.out_rdata, bus.out_tag, bus.out_err} !== o.r ||
          bus.in_ready !== 1'b0 || bus.mem_access !== 1'b0) bad = 1'b1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL bp_hold got out_valid=%b resp=%h in_ready=%b exp 1 %h 0",
                         bus.out_valid, {bus.out_rdata, bus.out_tag, bus.out_err}, bus.in_ready, o.r);
    end
    e = sb_q.pop_front();
    checks++;
    if (o.r !== e) begin errors++; $display("FAIL bp_resp got %h exp %h", o.r, e); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mem_access !== 1'b0) begin
      errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b mem_access=%b exp 0 1 0",
                         bus.out_valid, bus.in_ready, bus.mem_access);
    end
  endtask

  task automatic test_async_reset();
    logic strobe_seen = 1'b0;
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_is_store = 1'b0;
    bus.in_funct3 = 3'd2; bus.in_addr = 32'h8000_0004; bus.in_tag = 5'h11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mem_access !== 1'b1) begin errors++; $display("FAIL ar_in_access got mem_access=%b exp 1", bus.mem_access); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_access, bus.read, bus.wen, bus.in_ready, bus.out_valid} !== 5'b00010 || bus.raddr !== 32'h0) begin
      errors++; $display("FAIL ar_drop got acc/read/wen/in_ready/out_valid=%b raddr=%h exp 00010 0",
                         {bus.mem_access, bus.read, bus.wen, bus.in_ready, bus.out_valid}, bus.raddr);
    end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.mem_access !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) strobe_seen = 1'b1;
    end
    checks++;
    if (strobe_seen !== 1'b0) begin
      errors++; $display("FAIL ar_after_release got activity=%b in_ready=%b out_valid=%b exp 0 1 0",
                         strobe_seen, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    obs_t  o1, o2;
    resp_t e;
    sb_q.push_back('{32'h0, 5'h0A, 1'b0});
    do_req(1'b0, 1'b1, 3'd2, 32'h8000_0010, 32'h1122_3344, 5'h0A, o1);
    sb_q.push_back('{mem_load(32'h8000_0010, 3'd2), 5'h0B, 1'b0});
    do_req(1'b1, 1'b0, 3'd2, 32'h8000_0010, 32'h0, 5'h0B, o2);
    checks++;
    if (o2.acc_cyc - o1.acc_cyc !== 32'd4) begin
      errors++; $display("FAIL b2b_spacing got %0d exp 4", o2.acc_cyc - o1.acc_cyc);
    end
    checks++;
    if (o1.c_wmask !== 8'h0F || o1.c_wdata !== 32'h1122_3344 || o1.c_waddr !== 32'h8000_0010) begin
      errors++; $display("FAIL b2b_sw_cmd got wmask=%h wdata=%h waddr=%h exp 0f 11223344 80000010",
                         o1.c_wmask, o1.c_wdata, o1.c_waddr);
    end
    e = sb_q.pop_front();
    checks++;
    if (o1.r !== e) begin errors++; $display("FAIL b2b_first got %h exp %h", o1.r, e); end
    e = sb_q.pop_front();
    checks++;
    if (o2.r !== e) begin errors++; $display("FAIL b2b_second got %h exp %h", o2.r, e); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_is_load = 1'b0; bus.in_is_store = 1'b0;
    bus.in_funct3 = '0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_sb();
    test_lh();
    test_misaligned();
    test_mixed();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
